// File: rtl/scan_seq64_pkg.sv
// Shared definitions for the scan_seq64 index generator: state encoding,
// index width and the bounded index-step helper.
package scan_seq64_pkg;

  localparam int IDX_W = 6;
  localparam logic [IDX_W-1:0] IDX_MAX = 6'd63;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN
  } state_e;

  function automatic logic [IDX_W-1:0] idx_min(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [IDX_W-1:0] idx_max(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b);
    return (a < b) ? b : a;
  endfunction

  // Saturating step: the index can never wrap modulo 64 even if called at a rail.
  function automatic logic [IDX_W-1:0] idx_step(input logic [IDX_W-1:0] cur,
                                                input logic             down);
    logic [IDX_W-1:0] res;
    if (down) begin
      res = (cur == 6'd0) ? cur : cur - 6'd1;
    end else begin
      res = (cur == IDX_MAX) ? cur : cur + 6'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/scan_seq64_dwell_counter.sv
// Down-counter that sets how long each index is held; load takes priority
// over decrement and the counter stops at zero.
module dwell_counter #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [DW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [DW-1:0] r_cnt;

  // Count register: load, otherwise decrement while non-zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {DW{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != {DW{1'b0}})) begin
      r_cnt <= r_cnt - {{(DW-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == {DW{1'b0}});

endmodule

// File: rtl/scan_seq64.sv
// Sequential index generator for the 6-to-64 one-hot decoder: sweeps w across
// a shadowed [lo..hi] window, up or down, with programmable dwell per index.
module scan_seq64
  import scan_seq64_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_mode,
  input  logic             i_dir,
  input  logic [IDX_W-1:0] i_lo,
  input  logic [IDX_W-1:0] i_hi,
  input  logic [DW-1:0]    i_dwell,
  output logic             o_en,
  output logic [IDX_W-1:0] o_w,
  output logic             o_busy,
  output logic             o_tick,
  output logic             o_wrap,
  output logic             o_done
);

  state_e           r_state;
  logic             r_en;
  logic [IDX_W-1:0] r_w;
  logic             r_busy;
  logic             r_tick;
  logic             r_wrap;
  logic             r_done;

  logic             r_mode;
  logic             r_dir;
  logic [DW-1:0]    r_dwell;
  logic [IDX_W-1:0] r_lo;
  logic [IDX_W-1:0] r_hi;

  state_e           w_state_n;
  logic             w_en_n;
  logic [IDX_W-1:0] w_w_n;
  logic             w_busy_n;
  logic             w_tick_n;
  logic             w_wrap_n;
  logic             w_done_n;
  logic             w_cap;
  logic             w_load;
  logic [DW-1:0]    w_load_val;
  logic             w_dec;
  logic             w_zero;

  logic [IDX_W-1:0] w_lo_in;
  logic [IDX_W-1:0] w_hi_in;
  logic [IDX_W-1:0] w_first;
  logic [IDX_W-1:0] w_last;

  assign w_lo_in = idx_min(i_lo, i_hi);
  assign w_hi_in = idx_max(i_lo, i_hi);
  assign w_first = r_dir ? r_hi : r_lo;
  assign w_last  = r_dir ? r_lo : r_hi;

  dwell_counter #(
    .DW (DW)
  ) u_dwell (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // Next-state, index stepping and status-pulse decode.
  always_comb begin
    w_state_n  = r_state;
    w_en_n     = r_en;
    w_w_n      = r_w;
    w_busy_n   = r_busy;
    w_tick_n   = 1'b0;
    w_wrap_n   = 1'b0;
    w_done_n   = 1'b0;
    w_cap      = 1'b0;
    w_load     = 1'b0;
    w_load_val = r_dwell;
    w_dec      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && !i_stop) begin
          w_cap      = 1'b1;
          w_state_n  = ST_RUN;
          w_en_n     = 1'b1;
          w_busy_n   = 1'b1;
          w_w_n      = i_dir ? w_hi_in : w_lo_in;
          w_load     = 1'b1;
          w_load_val = i_dwell;
        end else begin
          w_en_n   = 1'b0;
          w_busy_n = 1'b0;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          w_state_n = ST_IDLE;
          w_en_n    = 1'b0;
          w_busy_n  = 1'b0;
        end else if (!w_zero) begin
          w_dec = 1'b1;
        end else if (r_w != w_last) begin
          w_w_n    = idx_step(r_w, r_dir);
          w_load   = 1'b1;
          w_tick_n = 1'b1;
        end else if (!r_mode) begin
          w_state_n = ST_IDLE;
          w_en_n    = 1'b0;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
        end else begin
          w_w_n    = w_first;
          w_load   = 1'b1;
          w_wrap_n = 1'b1;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_en_n    = 1'b0;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  // State and registered decoder-facing outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_en    <= 1'b0;
      r_w     <= 6'd0;
      r_busy  <= 1'b0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_en    <= w_en_n;
      r_w     <= w_w_n;
      r_busy  <= w_busy_n;
      r_tick  <= w_tick_n;
      r_wrap  <= w_wrap_n;
      r_done  <= w_done_n;
    end
  end

  // Shadow copies so input changes mid-sweep have no effect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode  <= 1'b0;
      r_dir   <= 1'b0;
      r_dwell <= {DW{1'b0}};
      r_lo    <= 6'd0;
      r_hi    <= 6'd0;
    end else if (w_cap) begin
      r_mode  <= i_mode;
      r_dir   <= i_dir;
      r_dwell <= i_dwell;
      r_lo    <= w_lo_in;
      r_hi    <= w_hi_in;
    end else begin
      r_mode  <= r_mode;
      r_dir   <= r_dir;
      r_dwell <= r_dwell;
      r_lo    <= r_lo;
      r_hi    <= r_hi;
    end
  end

  assign o_en   = r_en;
  assign o_w    = r_w;
  assign o_busy = r_busy;
  assign o_tick = r_tick;
  assign o_wrap = r_wrap;
  assign o_done = r_done;

endmodule

// File: tb/tb_scan_seq64.sv
// Directed bench for scan_seq64: a table of single sweeps plus hand-written
// sequences for reset, stop/start interplay and continuous wrap.
module tb_scan_seq64;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic       i_stop;
  logic       i_mode;
  logic       i_dir;
  logic [5:0] i_lo;
  logic [5:0] i_hi;
  logic [7:0] i_dwell;
  logic       o_en;
  logic [5:0] o_w;
  logic       o_busy;
  logic       o_tick;
  logic       o_wrap;
  logic       o_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [5:0] lo;
    logic [5:0] hi;
    logic [7:0] dwell;
    logic       dir;
    logic       disturb;
    logic [5:0] exp_first;
    logic [5:0] exp_last;
    int         exp_cycles;
    int         exp_ticks;
  } vec_t;

  vec_t vecs[8];

  scan_seq64 #(.DW(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (i_start),
    .i_stop  (i_stop),
    .i_mode  (i_mode),
    .i_dir   (i_dir),
    .i_lo    (i_lo),
    .i_hi    (i_hi),
    .i_dwell (i_dwell),
    .o_en    (o_en),
    .o_w     (o_w),
    .o_busy  (o_busy),
    .o_tick  (o_tick),
    .o_wrap  (o_wrap),
    .o_done  (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         cycles;
    int         ticks;
    logic [5:0] first;
    logic [5:0] last;
    logic [5:0] wlo;
    logic [5:0] whi;
    logic       oob;
    logic       wrap_seen;
    wlo = (v.exp_first < v.exp_last) ? v.exp_first : v.exp_last;
    whi = (v.exp_first < v.exp_last) ? v.exp_last : v.exp_first;
    i_lo = v.lo; i_hi = v.hi; i_dwell = v.dwell; i_dir = v.dir; i_mode = 1'b0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    if (v.disturb) begin
      i_start = 1'b1; i_lo = 6'd40; i_hi = 6'd50; i_dir = 1'b1; i_mode = 1'b1; i_dwell = 8'd5;
    end
    cycles = 0; ticks = 0; first = o_w; last = o_w; oob = 1'b0; wrap_seen = 1'b0;
    while (o_en && cycles < 300) begin
      last = o_w;
      cycles++;
      if (o_tick) ticks++;
      if (o_wrap) wrap_seen = 1'b1;
      if (o_w < wlo || o_w > whi) oob = 1'b1;
      step();
    end
    chk($sformatf("v%0d first", idx),  32'(first), 32'(v.exp_first));
    chk($sformatf("v%0d last", idx),   32'(last), 32'(v.exp_last));
    chk($sformatf("v%0d cycles", idx), 32'(cycles), 32'(v.exp_cycles));
    chk($sformatf("v%0d ticks", idx),  32'(ticks), 32'(v.exp_ticks));
    chk($sformatf("v%0d window", idx), 32'(oob), 32'd0);
    chk($sformatf("v%0d wrap", idx),   32'(wrap_seen), 32'd0);
    chk($sformatf("v%0d done", idx),   32'(o_done), 32'd1);
    chk($sformatf("v%0d busy", idx),   32'(o_busy), 32'd0);
    chk($sformatf("v%0d w hold", idx), 32'(o_w), 32'(v.exp_last));
    if (v.disturb) begin
      step();
      chk($sformatf("v%0d restart en", idx), 32'(o_en), 32'd1);
      chk($sformatf("v%0d restart busy", idx), 32'(o_busy), 32'd1);
      chk($sformatf("v%0d restart w", idx), 32'(o_w), 32'd50);
      i_start = 1'b0;
      i_stop  = 1'b1;
      step();
      i_stop = 1'b0;
      chk($sformatf("v%0d restart stop", idx), 32'(o_en), 32'd0);
    end
    step();
  endtask

  initial begin
    int k;
    rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_mode = 1'b0; i_dir = 1'b0;
    i_lo = 6'd0; i_hi = 6'd0; i_dwell = 8'd0;
    step();
    step();
    chk("reset en",   32'(o_en), 32'd0);
    chk("reset w",    32'(o_w), 32'd0);
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset tick", 32'(o_tick), 32'd0);
    chk("reset wrap", 32'(o_wrap), 32'd0);
    chk("reset done", 32'(o_done), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle busy", 32'(o_busy), 32'd0);

    vecs[0] = '{6'd2,  6'd5,  8'd0, 1'b0, 1'b0, 6'd2,  6'd5,  4, 3};
    vecs[1] = '{6'd9,  6'd7,  8'd0, 1'b0, 1'b0, 6'd7,  6'd9,  3, 2};
    vecs[2] = '{6'd0,  6'd0,  8'd3, 1'b0, 1'b0, 6'd0,  6'd0,  4, 0};
    vecs[3] = '{6'd60, 6'd63, 8'd1, 1'b1, 1'b0, 6'd63, 6'd60, 8, 3};
    vecs[4] = '{6'd63, 6'd63, 8'd0, 1'b0, 1'b0, 6'd63, 6'd63, 1, 0};
    vecs[5] = '{6'd0,  6'd2,  8'd0, 1'b1, 1'b0, 6'd2,  6'd0,  3, 2};
    vecs[6] = '{6'd62, 6'd63, 8'd0, 1'b0, 1'b0, 6'd62, 6'd63, 2, 1};
    vecs[7] = '{6'd2,  6'd5,  8'd0, 1'b0, 1'b1, 6'd2,  6'd5,  4, 3};
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Start and Stop together in IDLE: nothing starts.
    i_start = 1'b1; i_stop = 1'b1;
    step();
    chk("start+stop busy", 32'(o_busy), 32'd0);
    chk("start+stop en",   32'(o_en), 32'd0);
    i_start = 1'b0; i_stop = 1'b0;
    step();
    chk("start+stop later busy", 32'(o_busy), 32'd0);

    // Stop at w=4 aborts without Done.
    i_lo = 6'd2; i_hi = 6'd8; i_dwell = 8'd0; i_dir = 1'b0; i_mode = 1'b0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    k = 0;
    while (o_w != 6'd4 && k < 50) begin step(); k++; end
    chk("stop reach w4", 32'(o_w), 32'd4);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    chk("stop en",   32'(o_en), 32'd0);
    chk("stop busy", 32'(o_busy), 32'd0);
    chk("stop done", 32'(o_done), 32'd0);
    chk("stop tick", 32'(o_tick), 32'd0);
    chk("stop w",    32'(o_w), 32'd4);
    step();
    chk("stop no late done", 32'(o_done), 32'd0);

    // Descending continuous sweep 63..60, dwell 2, then wrap.
    i_lo = 6'd60; i_hi = 6'd63; i_dwell = 8'd2; i_dir = 1'b1; i_mode = 1'b1; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int j = 0; j < 12; j++) begin
      chk($sformatf("cont en %0d", j),   32'(o_en), 32'd1);
      chk($sformatf("cont w %0d", j),    32'(o_w), 32'(63 - j / 3));
      chk($sformatf("cont tick %0d", j), 32'(o_tick), 32'((j % 3 == 0) && (j > 0)));
      chk($sformatf("cont wrap %0d", j), 32'(o_wrap), 32'd0);
      step();
    end
    chk("cont wrap w",    32'(o_w), 32'd63);
    chk("cont wrap",      32'(o_wrap), 32'd1);
    chk("cont wrap en",   32'(o_en), 32'd1);
    chk("cont wrap tick", 32'(o_tick), 32'd0);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    chk("cont stop en",   32'(o_en), 32'd0);
    chk("cont stop done", 32'(o_done), 32'd0);
    chk("cont stop wrap", 32'(o_wrap), 32'd0);
    step();

    // One-index continuous window wraps every Dwell+1 cycles.
    i_lo = 6'd10; i_hi = 6'd10; i_dwell = 8'd1; i_dir = 1'b0; i_mode = 1'b1; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("one wrap %0d", j), 32'(o_wrap), 32'((j == 2) || (j == 4)));
      chk($sformatf("one w %0d", j),    32'(o_w), 32'd10);
      step();
    end
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    step();

    // Asynchronous reset mid-sweep, then a normal sweep.
    i_lo = 6'd2; i_hi = 6'd9; i_dwell = 8'd0; i_dir = 1'b0; i_mode = 1'b0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    k = 0;
    while (o_w != 6'd5 && k < 50) begin step(); k++; end
    chk("mid reset reach w5", 32'(o_w), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset en",   32'(o_en), 32'd0);
    chk("mid reset w",    32'(o_w), 32'd0);
    chk("mid reset busy", 32'(o_busy), 32'd0);
    chk("mid reset tick", 32'(o_tick), 32'd0);
    #2 rst_n = 1'b1;
    step();
    chk("post reset busy", 32'(o_busy), 32'd0);
    run_vec(vecs[0], 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
